vpu_line_dma: RTL and testbench

VPU_LINE_DMA -- requirements
Module: vpu_line_dma

---
 rtl/vpu_pkg.sv | 48 ++++
 rtl/vpu_line_buf.sv | 21 ++
 rtl/vpu_line_dma.sv | 232 +++++++++++++++++++++++
 tb/tb_vpu_line_dma.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_pkg.sv
// vpu_pkg: shared register map, control/status bit indices,
// fetch FSM encoding and small helpers for the VPU line DMA.
package vpu_pkg;

  localparam logic [3:0] A_CTRL  = 4'h0;
  localparam logic [3:0] A_STAT  = 4'h1;
  localparam logic [3:0] A_BASEH = 4'h2;
  localparam logic [3:0] A_BASEL = 4'h3;
  localparam logic [3:0] A_LEN   = 4'h4;
  localparam logic [3:0] A_ROWH  = 4'h5;
  localparam logic [3:0] A_SVLH  = 4'h6;
  localparam logic [3:0] A_SVLL  = 4'h7;
  localparam logic [3:0] A_EVLH  = 4'h8;
  localparam logic [3:0] A_EVLL  = 4'h9;

  localparam int C_EN  = 7;
  localparam int C_IEN = 6;
  localparam int C_GRF = 5;

  localparam int ST_IRQ  = 7;
  localparam int ST_UNDR = 6;
  localparam int ST_BUSY = 5;
  localparam int ST_BANK = 4;

  typedef enum logic [2:0] {
    DMA_IDLE = 3'd0,
    DMA_REQ  = 3'd1,
    DMA_ADDR = 3'd2,
    DMA_DATA = 3'd3,
    DMA_DONE = 3'd4
  } dma_state_e;

  // Packed in CTRL bit order (EN is bit 7).
  typedef struct packed {
    logic en;
    logic ien;
    logic grf;
  } ctrl_t;

  function automatic logic [8:0] clip_len(
    input logic [7:0] len,
    input int         depth
  );
    if (int'(len) > depth) return 9'(depth);
    return {1'b0, len};
  endfunction

endpackage

// File: rtl/vpu_line_buf.sv
// vpu_line_buf: two-bank line buffer, 2*DEPTH x 8 simple dual-port RAM.
// Ports: clk; we/waddr/wdata write port; raddr/rdata registered read.
module vpu_line_buf #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH):0]   waddr,
  input  logic [7:0]               wdata,
  input  logic [$clog2(DEPTH):0]   raddr,
  output logic [7:0]               rdata
);

  logic [7:0] mem [2*DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vpu_line_dma.sv
// vpu_line_dma: per-line text fetch DMA into a double-buffered line store.
// Ports: clk/rst; CPU regs AD/DI/DO/rw/cs; irq; hsync_stb/line_num raster;
// VADDR/VDATA/vramcs/hold/hlda memory bus; rd_addr/rd_data display read.
module vpu_line_dma
  import vpu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 64,
  parameter int LINE_W = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               AD,
  input  logic [7:0]               DI,
  output logic [7:0]               DO,
  input  logic                     rw,
  input  logic                     cs,
  output logic                     irq,
  input  logic                     hsync_stb,
  input  logic [LINE_W-1:0]        line_num,
  output logic [ADDR_W-1:0]        VADDR,
  input  logic [7:0]               VDATA,
  output logic                     vramcs,
  output logic                     hold,
  input  logic                     hlda,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [7:0]               rd_data
);

  localparam int IW = $clog2(DEPTH);

  dma_state_e state, state_n;
  ctrl_t ctrl;

  logic [15:0] base_r, svl_r, evl_r;
  logic [15:0] base_v, svl_v, evl_v;
  logic [7:0] len_r, rowh_r, rdata, q;
  logic [LINE_W-1:0] svl, evl;
  logic [ADDR_W-1:0] ptr, fstart;
  logic [8:0] flen, front_len, idx, len_c;
  logic [3:0] row, rowh_m1;
  logic irq_f, undr_f, bank, full, pend, rd_ok;
  logic wr, rd, stat_rd, at_evl, active;
  logic row_wrap, start, abort, last, we;

  assign wr      = cs & ~rw;
  assign rd      = cs & rw;
  assign stat_rd = rd & (AD == A_STAT);

  assign svl    = LINE_W'(svl_r);
  assign evl    = LINE_W'(evl_r);
  assign svl_v  = 16'(svl);
  assign evl_v  = 16'(evl);
  assign base_v = 16'(ADDR_W'(base_r));

  assign at_evl = hsync_stb & (line_num == evl);
  assign active = hsync_stb & ctrl.en
                & (line_num >= svl) & (line_num < evl);

  // >= rather than == so a ROWH shrink mid-frame cannot strand the counter.
  assign row_wrap = row >= rowh_m1;
  assign len_c    = clip_len(len_r, DEPTH);
  assign start    = active & (ctrl.grf | row_wrap) & (len_c != 9'd0);

  // A completed fetch sits in DONE with full set, so it is not aborted.
  assign abort = hsync_stb
               & (state inside {DMA_REQ, DMA_ADDR, DMA_DATA});
  assign last  = (idx + 9'd1) >= flen;
  assign we    = state == DMA_DATA;

  always_comb begin
    rowh_m1 = 4'd0;
    if (rowh_r > 8'd16) rowh_m1 = 4'd15;
    else if (rowh_r != 8'd0) rowh_m1 = 4'(rowh_r - 8'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DMA_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      DMA_IDLE: if (pend) state_n = DMA_REQ;
      DMA_REQ:  if (hlda) state_n = DMA_ADDR;
      DMA_ADDR: state_n = DMA_DATA;
      DMA_DATA: state_n = last ? DMA_DONE : DMA_ADDR;
      DMA_DONE: state_n = DMA_IDLE;
      default:  state_n = DMA_IDLE;
    endcase
    if (abort) state_n = DMA_IDLE;
  end

  // Address held through DATA so a registered memory sees it stable.
  always_comb begin
    hold   = 1'b0;
    vramcs = 1'b0;
    VADDR  = '0;
    unique case (state)
      DMA_ADDR: begin
        hold   = 1'b1;
        vramcs = 1'b1;
        VADDR  = ptr;
      end
      DMA_DATA: begin
        hold  = 1'b1;
        VADDR = ptr;
      end
      DMA_REQ, DMA_DONE: hold = 1'b1;
      default: hold = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl   <= '0;
      base_r <= '0;
      len_r  <= '0;
      rowh_r <= 8'd1;
      svl_r  <= '0;
      evl_r  <= '1;
    end else if (wr) begin
      unique case (AD)
        A_CTRL:  ctrl <= ctrl_t'(DI[7:5]);
        A_BASEH: base_r[15:8] <= DI;
        A_BASEL: base_r[7:0]  <= DI;
        A_LEN:   len_r <= DI;
        A_ROWH:  rowh_r <= DI;
        A_SVLH:  svl_r[15:8] <= DI;
        A_SVLL:  svl_r[7:0]  <= DI;
        A_EVLH:  evl_r[15:8] <= DI;
        A_EVLL:  evl_r[7:0]  <= DI;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_f     <= 1'b0;
      undr_f    <= 1'b0;
      bank      <= 1'b0;
      full      <= 1'b0;
      pend      <= 1'b0;
      rd_ok     <= 1'b0;
      row       <= '0;
      ptr       <= '0;
      fstart    <= '0;
      flen      <= '0;
      front_len <= '0;
      idx       <= '0;
    end else begin
      if (at_evl)       irq_f <= 1'b1;
      else if (stat_rd) irq_f <= 1'b0;
      if (abort)        undr_f <= 1'b1;
      else if (stat_rd) undr_f <= 1'b0;

      if (start) begin
        pend <= 1'b1;
        flen <= len_c;
      end else if (state == DMA_IDLE) begin
        pend <= 1'b0;
      end

      // Start pointer is latched on leaving IDLE so an abort's
      // pointer fix-up on the same hsync is picked up.
      if (state == DMA_IDLE && pend) begin
        fstart <= ptr;
        idx    <= '0;
      end
      if (we) begin
        idx <= idx + 9'd1;
        ptr <= ptr + 1'b1;
      end
      if (we && last && !abort) full <= 1'b1;

      if (hsync_stb) begin
        if (full) begin
          bank      <= ~bank;
          front_len <= flen;
        end
        full <= 1'b0;
      end

      if (abort) ptr <= fstart + ADDR_W'(flen);
      if (at_evl) begin
        ptr <= ADDR_W'(base_r);
        row <= rowh_m1;
      end else if (active) begin
        row <= row_wrap ? 4'd0 : row + 4'd1;
      end

      rd_ok <= 9'(rd_addr) < front_len;
    end
  end

  always_comb begin
    rdata = 8'h00;
    unique case (AD)
      A_CTRL:  rdata = {ctrl, 5'b0};
      A_STAT:  rdata = {irq_f, undr_f, state != DMA_IDLE, bank, 4'b0};
      A_BASEH: rdata = base_v[15:8];
      A_BASEL: rdata = base_v[7:0];
      A_LEN:   rdata = len_r;
      A_ROWH:  rdata = rowh_r;
      A_SVLH:  rdata = svl_v[15:8];
      A_SVLL:  rdata = svl_v[7:0];
      A_EVLH:  rdata = evl_v[15:8];
      A_EVLL:  rdata = evl_v[7:0];
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     DO <= '0;
    else if (rd) DO <= rdata;
  end

  assign irq     = irq_f & ctrl.ien;
  assign rd_data = rd_ok ? q : 8'h00;

  vpu_line_buf #(.DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr ({~bank, idx[IW-1:0]}),
    .wdata (VDATA),
    .raddr ({bank, rd_addr}),
    .rdata (q)
  );

endmodule

// File: tb/tb_vpu_line_dma.sv
// tb_vpu_line_dma: register table vectors, address scoreboard on the
// memory bus, and hand sequences for fetch, grant, abort, irq and reset.
module tb_vpu_line_dma;
  import vpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  AD;
  logic [7:0]  DI, DO;
  logic        rw, cs, irq, hsync_stb;
  logic [8:0]  line_num;
  logic [15:0] VADDR;
  logic [7:0]  VDATA, vdata_q;
  logic        vramcs, hold, hlda;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_data;

  int total = 0;
  int bad   = 0;
  int ncs   = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] e;
  } rv_t;

  rv_t rs[16];
  rv_t wv[11];

  vpu_line_dma dut (
    .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw),
    .cs(cs), .irq(irq), .hsync_stb(hsync_stb), .line_num(line_num),
    .VADDR(VADDR), .VDATA(VDATA), .vramcs(vramcs), .hold(hold),
    .hlda(hlda), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  always @(posedge clk) if (vramcs) vdata_q <= memf(VADDR);
  assign VDATA = vdata_q;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && vramcs) begin
      ncs++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL vaddr_extra: got %0h want none", VADDR);
      end else begin
        chk("vaddr", 64'(VADDR), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    @(negedge clk);
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [7:0] d);
    cs = 1'b1; rw = 1'b1; AD = a;
    @(negedge clk);
    cs = 1'b0;
    d = DO;
  endtask

  task automatic line(input int n);
    line_num = 9'(n); hsync_stb = 1'b1;
    @(negedge clk);
    hsync_stb = 1'b0;
  endtask

  task automatic rd_buf(input int a, output logic [7:0] d);
    rd_addr = 6'(a);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic push(input logic [15:0] s, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(s + 16'(i));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    exp_q.delete();
    cyc(1);
  endtask

  // Program a fetch setup and reload the pointer via an EVL line.
  task automatic setup(input logic [15:0] base, input logic [7:0] len,
                       input logic [7:0] ctl, input logic [7:0] rowh,
                       input int svl, input int evl);
    logic [7:0] d;
    wr_reg(A_BASEH, base[15:8]);
    wr_reg(A_BASEL, base[7:0]);
    wr_reg(A_LEN, len);
    wr_reg(A_ROWH, rowh);
    wr_reg(A_SVLH, 8'(svl >> 8));
    wr_reg(A_SVLL, 8'(svl));
    wr_reg(A_EVLH, 8'(evl >> 8));
    wr_reg(A_EVLL, 8'(evl));
    wr_reg(A_CTRL, ctl);
    line(evl);
    chk("irq_pin_evl", 64'(irq), 64'(ctl[C_IEN]));
    rd_reg(A_STAT, d);
    chk("stat_evl", 64'(d), 64'h80);
    chk("irq_cleared", 64'(irq), 64'h0);
  endtask

  initial begin
    logic [7:0] d;
    int hc, k;

    for (int i = 0; i < 16; i++) rs[i] = '{4'(i), 8'h00, 8'h00};
    rs[5].e = 8'h01;
    rs[8].e = 8'h01;
    rs[9].e = 8'hFF;

    wv[0]  = '{4'h0, 8'hFF, 8'hE0};
    wv[1]  = '{4'h1, 8'hFF, 8'h00};
    wv[2]  = '{4'h2, 8'h12, 8'h12};
    wv[3]  = '{4'h3, 8'h34, 8'h34};
    wv[4]  = '{4'h4, 8'h99, 8'h99};
    wv[5]  = '{4'h5, 8'h07, 8'h07};
    wv[6]  = '{4'h6, 8'h03, 8'h01};
    wv[7]  = '{4'h7, 8'hAB, 8'hAB};
    wv[8]  = '{4'h8, 8'hFE, 8'h00};
    wv[9]  = '{4'h9, 8'h55, 8'h55};
    wv[10] = '{4'hC, 8'h77, 8'h00};

    rst = 1'b1; cs = 1'b0; rw = 1'b1; AD = '0; DI = '0;
    hsync_stb = 1'b0; line_num = '0; hlda = 1'b1; rd_addr = '0;
    cyc(3);
    chk("reset_outs", {hold, vramcs, irq, DO, VADDR, rd_data}, 64'h0);
    rst = 1'b0;
    cyc(1);

    for (int i = 0; i < 16; i++) begin
      rd_reg(rs[i].a, d);
      chk($sformatf("rst_reg%0h", rs[i].a), 64'(d), 64'(rs[i].e));
    end
    for (int i = 0; i < 11; i++) begin
      wr_reg(wv[i].a, wv[i].d);
      rd_reg(wv[i].a, d);
      chk($sformatf("wr_reg%0h", wv[i].a), 64'(d), 64'(wv[i].e));
    end
    do_reset();

    // Basic GRF fetch, hold window and bank swap on the next line.
    setup(16'h1000, 8'd4, 8'hA0, 8'd1, 10, 20);
    push(16'h1000, 4);
    line(10);
    hc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (hold) hc++;
    end
    chk("hold_cycles", 64'(hc), 64'd10);
    rd_reg(A_STAT, d);
    chk("stat_before_swap", 64'(d), 64'h00);
    push(16'h1004, 4);
    line(11);
    rd_reg(A_STAT, d);
    chk("stat_bank1", 64'(d), 64'h10);
    cyc(20);
    chk("q_empty_a", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 5; i++) begin
      rd_buf(i, d);
      chk($sformatf("buf_a%0d", i), 64'(d),
          (i < 4) ? 64'(memf(16'h1000 + 16'(i))) : 64'h0);
    end
    do_reset();

    // Row-gated fetches every 8 lines, pointer advancing by LEN.
    setup(16'h2000, 8'd40, 8'h80, 8'd8, 10, 40);
    ncs = 0;
    k = 0;
    for (int ln = 10; ln < 34; ln++) begin
      if ((ln - 10) % 8 == 0) begin
        push(16'h2000 + 16'(40 * k), 40);
        k++;
      end
      line(ln);
      cyc(90);
    end
    chk("row_fetch_bytes", 64'(ncs), 64'd120);
    chk("q_empty_b", 64'(exp_q.size()), 64'd0);
    do_reset();

    // Bus grant withheld: no memory select until hlda.
    hlda = 1'b0;
    setup(16'h3000, 8'd3, 8'hA0, 8'd1, 10, 20);
    push(16'h3000, 3);
    line(10);
    hc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vramcs) hc++;
    end
    chk("no_cs_before_grant", 64'(hc), 64'd0);
    chk("hold_waiting", 64'(hold), 64'd1);
    hlda = 1'b1;
    cyc(20);
    chk("q_empty_c", 64'(exp_q.size()), 64'd0);
    push(16'h3003, 3);
    line(11);
    cyc(20);
    for (int i = 0; i < 4; i++) begin
      rd_buf(i, d);
      chk($sformatf("buf_c%0d", i), 64'(d),
          (i < 3) ? 64'(memf(16'h3000 + 16'(i))) : 64'h0);
    end
    do_reset();

    // Underrun: hsync mid-fetch aborts, pointer skips to start+LEN.
    setup(16'h4000, 8'd64, 8'hA0, 8'd1, 10, 20);
    push(16'h4000, 64);
    line(10);
    cyc(29);
    line(11);
    chk("hold_drop_abort", 64'(hold), 64'd0);
    exp_q.delete();
    push(16'h4040, 64);
    rd_reg(A_STAT, d);
    chk("stat_undr", 64'(d), 64'h40);
    cyc(150);
    chk("q_empty_d", 64'(exp_q.size()), 64'd0);
    do_reset();

    // Frame irq, then reset in the middle of a fetch.
    setup(16'h0000, 8'd0, 8'hC0, 8'd1, 10, 20);
    line(19);
    chk("irq_not_evl", 64'(irq), 64'd0);
    wr_reg(A_LEN, 8'd20);
    push(16'h0000, 20);
    line(10);
    cyc(10);
    chk("hold_mid_fetch", 64'(hold), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_drops_bus", {hold, vramcs}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    cyc(1);
    rd_buf(0, d);
    chk("rd_after_rst", 64'(d), 64'h0);
    rd_reg(A_STAT, d);
    chk("stat_after_rst", 64'(d), 64'h00);

    // LEN above DEPTH is clipped; LEN of zero skips the fetch.
    setup(16'h5000, 8'd70, 8'hA0, 8'd1, 10, 20);
    push(16'h5000, 64);
    ncs = 0;
    line(10);
    cyc(150);
    chk("clip_bytes", 64'(ncs), 64'd64);
    push(16'h5040, 64);
    line(11);
    cyc(150);
    rd_buf(0, d);
    chk("buf_f0", 64'(d), 64'(memf(16'h5000)));
    rd_buf(63, d);
    chk("buf_f63", 64'(d), 64'(memf(16'h503F)));
    wr_reg(A_LEN, 8'd0);
    ncs = 0;
    line(12);
    hc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (hold) hc++;
    end
    chk("len0_no_hold", 64'(hc), 64'd0);
    chk("len0_no_cs", 64'(ncs), 64'd0);
    chk("q_empty_f", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
